ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction-fetch unit that generates the PC stream, issues requests to instruction memory and delivers fetched {instruction, PC, PC+4} triples to the fetch/decode pipeline register (`Instruction`, `PC_Out`, `adder_out1`). It is the producer side of the fetch/decode interface. It honours hazard-unit stalls and branch/jump redirects from later stages. One memory request is outstanding at a time, with back-to-back issue for one instruction per cycle.

## Interface
- `RESET_PC`, 64'h0: fetch address after reset.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  64  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response data valid; no backpressure, must be accepted.
- `imem_rsp_data`  in  32  instruction word.
- `stall`  in  1  hazard unit: hold output entry.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  64  new fetch address; bits [1:0] are ignored and forced to 0.
- `out_valid`  out  1  output entry valid.
- `out_instruction`  out  32  to `Instruction`.
- `out_pc`  out  64  to `PC_Out`.
- `out_pc_plus4`  out  64  to `adder_out1`.

## Operation
- Registers:
  - `fetch_pc`: next address.
  - `inflight_pc`: address of the outstanding request.
  - Output entry O, which drives the `out_*` ports.
  - One-entry buffer B.
  - State.
- Handoff: O is consumed at an edge where `out_valid=1` and `stall=0`.
- States:
  - **S_REQ**: `imem_req_valid=1` when B is empty and `redirect_valid=0`. `imem_req_addr=fetch_pc`. On handshake, `inflight_pc<=fetch_pc`, `fetch_pc<=fetch_pc+4`, go to S_WAIT.
  - **S_WAIT**: on `imem_rsp_valid`, the entry {data, `inflight_pc`, `inflight_pc+4`} is written to O if O is empty or handing off, otherwise to B. Then:
    - If the entry goes to O and there is no redirect, a new request is asserted in the same cycle. On handshake, stay in S_WAIT with `inflight_pc` updated.
    - Otherwise go to S_REQ.
  - **S_DISCARD**: the next response is dropped, then go to S_REQ. No requests are issued in this state.
- B refill: when O hands off and B is full, O<=B and B is emptied.
- Redirect (highest priority, beats `stall`):
  - O and B are invalidated.
  - `fetch_pc<=redirect_pc&~3`.
  - `imem_req_valid` is forced low that cycle.
  - From S_WAIT with no response that cycle, go to S_DISCARD. A same-cycle response is dropped and the next state is S_REQ.
  - From S_DISCARD, stay in S_DISCARD.
- Arithmetic: PC+4 wraps modulo 2^64.
- Reset values:
  - `out_valid=0`, `out_instruction=0`, `out_pc=0`, `out_pc_plus4=0`.
  - `imem_req_valid=0` during reset; `imem_req_addr=RESET_PC`.
  - B empty, state S_REQ, `fetch_pc=RESET_PC`, `inflight_pc=0`.
- Reset mid-transaction: any later response for a pre-reset request is the memory's responsibility. The memory must squash it on reset.

## Timing
- With a zero-wait memory (`imem_req_ready=1`, response in the cycle after the handshake):
  - First request is issued in cycle 0 after reset release.
  - `out_valid=1` from cycle 2.
  - Steady state is one instruction per cycle.
- Request handshake to `out_valid`: 2 edges when O is free.
- Redirect at edge N: `out_valid=0` in cycle N+1. The request for `redirect_pc` appears in cycle N+1, or after the discarded response if in S_WAIT.
- During `stall`, the `out_*` ports are stable. At most one additional instruction is fetched, into B, and then requests stop.

## Configuration
- `IFU_BUBBLE_NOP_EN`:
  - Defined: when `out_valid=0`, `out_instruction=32'h00000013` (`addi x0,x0,0`), and `out_pc`/`out_pc_plus4` are 0. The downstream register captures a true bubble.
  - Undefined: invalid entries keep their last data; downstream must qualify with `out_valid`.

## Structure
- Package `ifu_pkg`:
  - `NOP_INSTR` constant.
  - `ifu_state_t` enum (S_REQ, S_WAIT, S_DISCARD).
  - `fetch_entry_t` struct {instr[31:0], pc[63:0], pc4[63:0]}.
- Sub-module `ifu_entry_buf`: holds O plus B, with write, handoff and flush ports and full/empty flags. The FSM and PC logic stay in `ifu_fetch`.

## Test plan
- Reset with `RESET_PC=64'h1000`, zero-wait memory returning addr-derived data -> outputs 0 during reset. `out_pc` sequence is 1000, 1004, 1008…, one per cycle from cycle 2, with `out_pc_plus4=out_pc+4`.
- `stall` held 3 cycles while streaming -> `out_*` frozen and one entry lands in B. `imem_req_valid=0` after that. On release, the B entry appears next, with no loss or duplication.
- `redirect_valid` with `redirect_pc=64'h2003` while a response is pending -> `out_valid=0`, the stale response is dropped, and the next `out_pc=64'h2000`.
- Redirect and `stall` asserted in the same cycle -> flush wins and fetch restarts at `redirect_pc`.
- `imem_req_ready` low for 4 cycles -> `imem_req_addr` held constant and `out_valid` drops after the last entry. `fetch_pc=64'hFFFF_FFFF_FFFF_FFFC` wraps to `out_pc_plus4=0`.
- With `IFU_BUBBLE_NOP_EN` defined, a redirect bubble -> `out_instruction=32'h00000013`.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch unit.
// Contents: NOP_INSTR bubble word, ifu_state_t fetch FSM states,
//           fetch_entry_t {instr, pc, pc4} triple, PC helper functions.
package ifu_pkg;

  // addi x0,x0,0 -- the canonical RISC-V no-op used for pipeline bubbles.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,  // ready to issue a request at fetch_pc
    S_WAIT    = 2'd1,  // one request outstanding, waiting for its response
    S_DISCARD = 2'd2   // outstanding response belongs to a flushed path
  } ifu_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pc4;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^64 by construction.
  function automatic logic [63:0] pc_inc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

  // Fetch addresses are always word aligned.
  function automatic logic [63:0] word_align(input logic [63:0] pc);
    return pc & ~64'h3;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundles the instruction-memory request/response channel,
// the hazard/redirect controls and the fetch/decode output entry.
// master = fetch unit side, slave = memory + pipeline side.
interface ifu_fetch_if;

  // instruction memory request / response
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // controls from later stages
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  // output entry towards the fetch/decode register
  logic        out_valid;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic [63:0] out_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  stall, redirect_valid, redirect_pc,
    output out_valid, out_instruction, out_pc, out_pc_plus4
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output stall, redirect_valid, redirect_pc,
    input  out_valid, out_instruction, out_pc, out_pc_plus4
  );

endinterface

// File: rtl/ifu_entry_buf.sv
// ifu_entry_buf: output entry O plus one-entry overflow buffer B.
// Latency: a write lands in O (or B) at the next edge; O refills from B on handoff.
// Backpressure: handoff is the consumer's acceptance; B absorbs one entry while O is held.
// Ports: wr_en/wr_entry write, handoff consume O, flush drop both,
//        o_valid/o_entry drive the output, o_free (next write goes to O), b_full.
module ifu_entry_buf
  import ifu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr_en,
  input  fetch_entry_t wr_entry,
  input  logic         handoff,
  output logic         o_valid,
  output fetch_entry_t o_entry,
  output logic         o_free,
  output logic         b_full
);

  logic         o_valid_q, o_valid_d;
  fetch_entry_t o_entry_q, o_entry_d;
  logic         b_valid_q, b_valid_d;
  fetch_entry_t b_entry_q, b_entry_d;
  logic         take;

  // Only a valid O can be consumed.
  assign take = handoff && o_valid_q;

  always_comb begin
    o_valid_d = o_valid_q;
    o_entry_d = o_entry_q;
    b_valid_d = b_valid_q;
    b_entry_d = b_entry_q;

    if (flush) begin
      // Data is kept; only the valid bits are dropped.
      o_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else if (take) begin
      if (b_valid_q) begin
        o_valid_d = 1'b1;
        o_entry_d = b_entry_q;
        b_valid_d = wr_en;
        if (wr_en) begin
          b_entry_d = wr_entry;
        end
      end else if (wr_en) begin
        o_valid_d = 1'b1;
        o_entry_d = wr_entry;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (wr_en) begin
      if (!o_valid_q) begin
        o_valid_d = 1'b1;
        o_entry_d = wr_entry;
      end else begin
        b_valid_d = 1'b1;
        b_entry_d = wr_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid_q <= 1'b0;
      o_entry_q <= '0;
      b_valid_q <= 1'b0;
      b_entry_q <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_entry_q <= o_entry_d;
      b_valid_q <= b_valid_d;
      b_entry_q <= b_entry_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_entry = o_entry_q;
  assign b_full  = b_valid_q;
  // A write goes straight to O when O is empty or leaving this edge and
  // nothing older is queued in B.
  assign o_free  = (!o_valid_q || take) && !b_valid_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC generation, single-outstanding imem requests, delivery of
// {instruction, PC, PC+4} to the fetch/decode register.
// Latency: request handshake to out_valid is 2 edges; steady state 1 instr/cycle.
// Backpressure: stall holds O; one more fetch lands in B, then requests stop.
// Ports: clk, reset (async, active-high), bus (ifu_fetch_if.master).
// Parameter RESET_PC: first fetch address after reset.
// Build option IFU_BUBBLE_NOP_EN: when defined, invalid output entries read as
// NOP_INSTR with zero PCs; otherwise they keep their last data.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
)
(
  input  logic        clk,
  input  logic        reset,
  ifu_fetch_if.master bus
);

  ifu_state_t   state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  inflight_pc_q, inflight_pc_d;

  logic         req_vld;
  logic         req_fire;
  logic         buf_wr;
  logic         handoff;
  logic         o_free;
  logic         b_full;
  logic         o_valid;
  fetch_entry_t o_entry;
  fetch_entry_t rsp_entry;

  assign handoff   = o_valid && !bus.stall;
  assign rsp_entry = '{instr: bus.imem_rsp_data,
                       pc:    inflight_pc_q,
                       pc4:   pc_inc(inflight_pc_q)};
  assign req_fire  = req_vld && bus.imem_req_ready;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    req_vld       = 1'b0;
    buf_wr        = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // With B occupied there is no room for another response.
        req_vld = !b_full && !bus.redirect_valid;
        if (req_vld && bus.imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (bus.redirect_valid) begin
            // Response of the flushed path arrives now: drop it.
            state_d = S_REQ;
          end else begin
            buf_wr = 1'b1;
            if (o_free) begin
              // Back-to-back: next request overlaps the response cycle.
              req_vld = 1'b1;
              state_d = bus.imem_req_ready ? S_WAIT : S_REQ;
            end else begin
              state_d = S_REQ;
            end
          end
        end else if (bus.redirect_valid) begin
          state_d = S_DISCARD;
        end
      end

      S_DISCARD: begin
        // The response consumed here is the stale one, even if a further
        // redirect arrives alongside it; nothing else is outstanding.
        if (bus.imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase

    if (req_fire) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = pc_inc(fetch_pc_q);
    end

    if (bus.redirect_valid) begin
      fetch_pc_d = word_align(bus.redirect_pc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  ifu_entry_buf u_entry_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.redirect_valid),
    .wr_en    (buf_wr),
    .wr_entry (rsp_entry),
    .handoff  (handoff),
    .o_valid  (o_valid),
    .o_entry  (o_entry),
    .o_free   (o_free),
    .b_full   (b_full)
  );

  // The state register reads S_REQ during reset; keep the request quiet.
  assign bus.imem_req_valid = req_vld && !reset;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.out_valid      = o_valid;

`ifdef IFU_BUBBLE_NOP_EN
  assign bus.out_instruction = o_valid ? o_entry.instr : NOP_INSTR;
  assign bus.out_pc          = o_valid ? o_entry.pc    : 64'h0;
  assign bus.out_pc_plus4    = o_valid ? o_entry.pc4   : 64'h0;
`else
  assign bus.out_instruction = o_entry.instr;
  assign bus.out_pc          = o_entry.pc;
  assign bus.out_pc_plus4    = o_entry.pc4;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: bench for ifu_fetch with a latency-configurable memory model
// and an in-order PC-stream scoreboard.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // stimulus knobs
  logic        drv_stall = 1'b0;
  logic        drv_redir = 1'b0;
  logic [63:0] drv_rpc   = 64'h0;
  int          rdy_pct   = 100;
  int          lat_min   = 1;
  int          lat_max   = 1;

  // memory model: one pending response
  logic        pend      = 1'b0;
  logic [63:0] pend_addr = 64'h0;
  int          pend_cnt  = 0;

  // reference: the next PC the pipeline must receive
  logic [63:0] exp_pc    = RST_PC;
  int          n_handoff = 0;
  int          first_ov;
  int          base;

  // samples of the most recent cycle
  logic        s_ov = 1'b0, s_rv = 1'b0, s_rdy = 1'b0, s_stall = 1'b0, s_redir = 1'b0;
  logic [63:0] s_pc = '0, s_pc4 = '0, s_addr = '0;
  logic [31:0] s_instr = '0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'hC0DE_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, sample #1 later, check, advance models.
  task automatic cycle();
    logic rsp;
    logic hs;
    rsp = 1'b0;
    if (pend) begin
      pend_cnt--;
      rsp = (pend_cnt == 0);
    end
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? instr_of(pend_addr) : 32'hBAD0_BAD0;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.stall          = drv_stall;
    bus.redirect_valid = drv_redir;
    bus.redirect_pc    = drv_rpc;
    #1;

    if (s_redir) begin
      check("bubble_after_redirect", bus.out_valid, 0);
`ifdef IFU_BUBBLE_NOP_EN
      check("bubble_nop_instr", bus.out_instruction, NOP_INSTR);
      check("bubble_zero_pc", bus.out_pc, 0);
`endif
    end else if (s_ov && s_stall) begin
      check("stall_hold_valid", bus.out_valid, 1);
      check("stall_hold_pc", bus.out_pc, s_pc);
      check("stall_hold_pc4", bus.out_pc_plus4, s_pc4);
      check("stall_hold_instr", bus.out_instruction, s_instr);
    end
    if (s_rv && !s_rdy) begin
      check("req_addr_hold", bus.imem_req_addr, s_addr);
      check("req_valid_hold", bus.imem_req_valid, !bus.redirect_valid);
    end
    if (bus.redirect_valid) check("redirect_blocks_req", bus.imem_req_valid, 0);
    if (bus.imem_req_valid) check("req_aligned", bus.imem_req_addr[1:0], 0);

    hs = bus.imem_req_valid && bus.imem_req_ready;
    if (hs) check("single_outstanding", pend && !rsp, 0);

    if (bus.out_valid && !bus.stall) begin
      check("out_pc", bus.out_pc, exp_pc);
      check("out_pc_plus4", bus.out_pc_plus4, exp_pc + 64'd4);
      check("out_instruction", bus.out_instruction, instr_of(exp_pc));
      exp_pc = exp_pc + 64'd4;
      n_handoff++;
    end
    if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~64'h3;

    if (rsp) pend = 1'b0;
    if (hs) begin
      pend      = 1'b1;
      pend_addr = bus.imem_req_addr;
      pend_cnt  = $urandom_range(lat_max, lat_min);
    end

    s_ov    = bus.out_valid;
    s_rv    = bus.imem_req_valid;
    s_rdy   = bus.imem_req_ready;
    s_stall = bus.stall;
    s_redir = bus.redirect_valid;
    s_pc    = bus.out_pc;
    s_pc4   = bus.out_pc_plus4;
    s_addr  = bus.imem_req_addr;
    s_instr = bus.out_instruction;
    @(posedge clk);
    #1;
  endtask

  // Run until the next valid output entry (bounded) and check its PC.
  task automatic wait_out(input string tag, input logic [63:0] pc);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!s_ov && k < 40);
    check(tag, s_ov ? s_pc : 64'hDEAD_DEAD_DEAD_DEAD, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_out_valid", bus.out_valid, 0);
`ifdef IFU_BUBBLE_NOP_EN
    check("rst_out_instruction", bus.out_instruction, NOP_INSTR);
`else
    check("rst_out_instruction", bus.out_instruction, 0);
`endif
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_pc_plus4", bus.out_pc_plus4, 0);
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_req_addr", bus.imem_req_addr, RST_PC);
    reset = 1'b0;

    // zero-wait streaming from RESET_PC
    first_ov = -1;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (k == 0) check("first_req_cycle0", s_rv, 1);
      if (s_ov && first_ov < 0) first_ov = k;
    end
    check("first_out_valid_cycle", first_ov, 2);
    check("zero_wait_throughput", n_handoff, 12);

    // stall for 3 cycles while streaming
    drv_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (k > 0) check("stall_stops_requests", s_rv, 0);
    end
    drv_stall = 1'b0;
    base = n_handoff;
    repeat (6) cycle();
    check("stall_release_count", n_handoff - base, 5);

    // redirect to an unaligned target while a response is pending
    lat_min = 2;
    lat_max = 2;
    for (int k = 0; k < 20 && !(pend && pend_cnt > 1); k++) cycle();
    check("pending_window_found", pend && pend_cnt > 1, 1);
    drv_redir = 1'b1;
    drv_rpc   = 64'h2003;
    cycle();
    drv_redir = 1'b0;
    wait_out("redirect_target_pc", 64'h2000);
    lat_min = 1;
    lat_max = 1;

    // redirect and stall together: flush wins
    repeat (5) cycle();
    drv_stall = 1'b1;
    drv_redir = 1'b1;
    drv_rpc   = 64'h3000;
    cycle();
    drv_stall = 1'b0;
    drv_redir = 1'b0;
    wait_out("stall_redirect_pc", 64'h3000);

    // memory not ready for 4 cycles: output drains
    repeat (5) cycle();
    rdy_pct = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k == 3) check("drain_after_ready_low", s_ov, 0);
    end
    rdy_pct = 100;

    // PC+4 wraps at the top of the address space
    drv_redir = 1'b1;
    drv_rpc   = 64'hFFFF_FFFF_FFFF_FFFE;
    cycle();
    drv_redir = 1'b0;
    wait_out("wrap_pc", 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc_plus4", s_pc4, 64'h0);
    repeat (4) cycle();

    // randomized traffic
    lat_max = 3;
    rdy_pct = 70;
    for (int k = 0; k < 3000; k++) begin
      drv_stall = ($urandom_range(99) < 25);
      drv_redir = ($urandom_range(99) < 4);
      drv_rpc   = {$urandom, $urandom};
      cycle();
    end
    drv_stall = 1'b0;
    drv_redir = 1'b0;
    rdy_pct   = 100;
    repeat (10) cycle();
    check("random_progress", n_handoff > 300, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
